// File: rtl/l0_cache_read_controller.sv
// l0_cache_read_controller
//   Drives the L0 data-cache read port from the EX-stage load address so the
//   array output lines up with the MA stage, merges same-cycle snooped writes
//   into the array output (read bypass), and produces the MA-stage load hit.
//   Also runs the whole-cache invalidation sweep (one index per cycle).
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_stall                      pipeline stall, EX->MA advances only when 0
//   i_is_load_ex                 EX holds a load
//   i_data_memory_address_ex     EX load address
//   i_load_byte_enable_ex        bytes the load needs
//   o_cache_read_index           cache array read address
//   i_cache_read_*               array data/tag/byte-valid (1-cycle, read-first)
//   i_cache_write_*, i_cache_byte_write_enable   snooped array write
//   i_invalidate_req             request to invalidate the whole cache
//   o_inval_write_enable/index   sweep write (valid=0) port
//   o_invalidate_busy            sweep active, pipeline stall source
//   o_invalidate_done            one-cycle pulse on the last sweep cycle
//   o_cache_hit_on_load          MA-stage load hit
//   o_cache_read_data_ma         MA-stage cache data after bypass merge
module l0_cache_read_controller #(
   parameter int unsigned          XLEN            = 32,
   parameter int unsigned          CacheIndexWidth = 7,
   parameter int unsigned          CacheTagWidth   = 7,
   parameter logic [XLEN-1:0]      MMIO_ADDR       = 32'h4000_0000
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_stall,
   input  logic                       i_is_load_ex,
   input  logic [XLEN-1:0]            i_data_memory_address_ex,
   input  logic [XLEN/8-1:0]          i_load_byte_enable_ex,
   output logic [CacheIndexWidth-1:0] o_cache_read_index,
   input  logic [XLEN-1:0]            i_cache_read_data,
   input  logic [CacheTagWidth-1:0]   i_cache_read_tag,
   input  logic [XLEN/8-1:0]          i_cache_read_valid,
   input  logic                       i_cache_write_enable,
   input  logic [CacheIndexWidth-1:0] i_cache_write_index,
   input  logic [XLEN-1:0]            i_cache_write_data,
   input  logic [CacheTagWidth-1:0]   i_cache_write_tag,
   input  logic [XLEN/8-1:0]          i_cache_write_valid,
   input  logic [XLEN/8-1:0]          i_cache_byte_write_enable,
   input  logic                       i_invalidate_req,
   output logic                       o_inval_write_enable,
   output logic [CacheIndexWidth-1:0] o_inval_write_index,
   output logic                       o_invalidate_busy,
   output logic                       o_invalidate_done,
   output logic                       o_cache_hit_on_load,
   output logic [XLEN-1:0]            o_cache_read_data_ma
);

   localparam int unsigned IW = CacheIndexWidth;
   localparam int unsigned TW = CacheTagWidth;
   localparam int unsigned BW = XLEN / 8;
   localparam logic [IW-1:0] LAST_INDEX = '1;

   typedef enum logic {
      IDLE,
      SWEEP
   } inval_state_t;

   inval_state_t  state;
   logic [IW-1:0] counter;
   logic          pending;

   // EX-stage address decode
   logic [IW-1:0] index_ex;
   logic [TW-1:0] tag_ex;
   logic          mmio_ex;

   assign index_ex = i_data_memory_address_ex[2 +: IW];
   assign tag_ex   = i_data_memory_address_ex[(2 + IW) +: TW];
   assign mmio_ex  = (i_data_memory_address_ex >= MMIO_ADDR);

   // MA-stage copy of the load
   logic [IW-1:0] index_ma;
   logic [TW-1:0] tag_ma;
   logic [BW-1:0] be_ma;
   logic          is_load_ma;
   logic          mmio_ma;

   always_ff @(posedge i_clk) begin
      if (!i_stall) begin
         index_ma <= index_ex;
         tag_ma   <= tag_ex;
         be_ma    <= i_load_byte_enable_ex;
         mmio_ma  <= mmio_ex;
      end
      if (i_rst)
         is_load_ma <= 1'b0;
      else if (!i_stall)
         is_load_ma <= i_is_load_ex;
   end

   // Hold the MA index while stalled so the array output keeps tracking MA.
   always_comb begin
      if (state == SWEEP)
         o_cache_read_index = counter;
      else if (i_stall)
         o_cache_read_index = index_ma;
      else
         o_cache_read_index = index_ex;
   end

   // Read bypass: a write to the index being read this cycle is not visible
   // in the read-first array output next cycle, so capture it and merge.
   logic          byp_hit;
   logic [XLEN-1:0] byp_data;
   logic [TW-1:0] byp_tag;
   logic [BW-1:0] byp_valid;
   logic [BW-1:0] byp_be;

   always_ff @(posedge i_clk) begin
      if (i_rst)
         byp_hit <= 1'b0;
      else
         byp_hit <= i_cache_write_enable && (i_cache_write_index == o_cache_read_index);
      byp_data  <= i_cache_write_data;
      byp_tag   <= i_cache_write_tag;
      byp_valid <= i_cache_write_valid;
      byp_be    <= i_cache_byte_write_enable;
   end

   logic [XLEN-1:0] m_data;
   logic [TW-1:0]   m_tag;
   logic [BW-1:0]   m_valid;

   always_comb begin
      m_data  = i_cache_read_data;
      m_tag   = i_cache_read_tag;
      m_valid = i_cache_read_valid;
      if (byp_hit) begin
         m_tag   = byp_tag;
         m_valid = byp_valid;
         for (int unsigned b = 0; b < BW; b++) begin
            if (byp_be[b])
               m_data[8*b +: 8] = byp_data[8*b +: 8];
         end
      end
   end

   // Invalidation sweep
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         counter <= '0;
         pending <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_invalidate_req) begin
                  state   <= SWEEP;
                  counter <= '0;
                  pending <= 1'b0;
               end
            end
            SWEEP: begin
               counter <= counter + 1'b1;
               if (counter == LAST_INDEX) begin
                  // A request seen during the sweep (or on its last cycle)
                  // restarts from index 0; the counter wraps there naturally.
                  if (!(pending || i_invalidate_req))
                     state <= IDLE;
                  pending <= 1'b0;
               end else if (i_invalidate_req) begin
                  pending <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_inval_write_enable = (state == SWEEP) && !i_rst;
   assign o_inval_write_index  = counter;
   assign o_invalidate_done    = (state == SWEEP) && (counter == LAST_INDEX) && !i_rst;
   assign o_invalidate_busy    = !i_rst && ((state == SWEEP) || i_invalidate_req);

   assign o_cache_hit_on_load = !i_rst && is_load_ma && !mmio_ma && (m_tag == tag_ma)
                                && ((be_ma & ~m_valid) == '0) && !o_invalidate_busy;
   assign o_cache_read_data_ma = i_rst ? '0 : m_data;

endmodule

// File: tb/tb_l0_cache_read_controller.sv
module tb_l0_cache_read_controller;

   localparam int XLEN = 32;
   localparam int IW   = 7;
   localparam int TW   = 7;
   localparam int BW   = 4;
   localparam int N    = 128;

   logic            i_clk = 1'b0;
   logic            i_rst;
   logic            i_stall;
   logic            i_is_load_ex;
   logic [31:0]     i_data_memory_address_ex;
   logic [3:0]      i_load_byte_enable_ex;
   logic [IW-1:0]   o_cache_read_index;
   logic [31:0]     i_cache_read_data;
   logic [TW-1:0]   i_cache_read_tag;
   logic [3:0]      i_cache_read_valid;
   logic            i_cache_write_enable;
   logic [IW-1:0]   i_cache_write_index;
   logic [31:0]     i_cache_write_data;
   logic [TW-1:0]   i_cache_write_tag;
   logic [3:0]      i_cache_write_valid;
   logic [3:0]      i_cache_byte_write_enable;
   logic            i_invalidate_req;
   logic            o_inval_write_enable;
   logic [IW-1:0]   o_inval_write_index;
   logic            o_invalidate_busy;
   logic            o_invalidate_done;
   logic            o_cache_hit_on_load;
   logic [31:0]     o_cache_read_data_ma;

   l0_cache_read_controller #(
      .XLEN            (32),
      .CacheIndexWidth (7),
      .CacheTagWidth   (7),
      .MMIO_ADDR       (32'h4000_0000)
   ) dut (
      .i_clk                     (i_clk),
      .i_rst                     (i_rst),
      .i_stall                   (i_stall),
      .i_is_load_ex              (i_is_load_ex),
      .i_data_memory_address_ex  (i_data_memory_address_ex),
      .i_load_byte_enable_ex     (i_load_byte_enable_ex),
      .o_cache_read_index        (o_cache_read_index),
      .i_cache_read_data         (i_cache_read_data),
      .i_cache_read_tag          (i_cache_read_tag),
      .i_cache_read_valid        (i_cache_read_valid),
      .i_cache_write_enable      (i_cache_write_enable),
      .i_cache_write_index       (i_cache_write_index),
      .i_cache_write_data        (i_cache_write_data),
      .i_cache_write_tag         (i_cache_write_tag),
      .i_cache_write_valid       (i_cache_write_valid),
      .i_cache_byte_write_enable (i_cache_byte_write_enable),
      .i_invalidate_req          (i_invalidate_req),
      .o_inval_write_enable      (o_inval_write_enable),
      .o_inval_write_index       (o_inval_write_index),
      .o_invalidate_busy         (o_invalidate_busy),
      .o_invalidate_done         (o_invalidate_done),
      .o_cache_hit_on_load       (o_cache_hit_on_load),
      .o_cache_read_data_ma      (o_cache_read_data_ma)
   );

   always #5 i_clk = ~i_clk;

   // Cache array environment: read-first, 1-cycle latency; preload port for the bench.
   logic [31:0]   mem_data  [N];
   logic [TW-1:0] mem_tag   [N];
   logic [3:0]    mem_valid [N];
   logic          pre_en;
   logic [IW-1:0] pre_idx;
   logic [31:0]   pre_data;
   logic [TW-1:0] pre_tag;
   logic [3:0]    pre_valid;

   always @(posedge i_clk) begin
      i_cache_read_data  <= mem_data[o_cache_read_index];
      i_cache_read_tag   <= mem_tag[o_cache_read_index];
      i_cache_read_valid <= mem_valid[o_cache_read_index];
      if (pre_en) begin
         mem_data[pre_idx]  <= pre_data;
         mem_tag[pre_idx]   <= pre_tag;
         mem_valid[pre_idx] <= pre_valid;
      end
      if (o_inval_write_enable)
         mem_valid[o_inval_write_index] <= 4'h0;
      if (i_cache_write_enable) begin
         for (int b = 0; b < BW; b++)
            if (i_cache_byte_write_enable[b])
               mem_data[i_cache_write_index][8*b +: 8] <= i_cache_write_data[8*b +: 8];
         mem_tag[i_cache_write_index]   <= i_cache_write_tag;
         mem_valid[i_cache_write_index] <= i_cache_write_valid;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [IW-1:0] idx_of(input logic [31:0] a);
      return a[8:2];
   endfunction

   function automatic logic [TW-1:0] tag_of(input logic [31:0] a);
      return a[15:9];
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_stall = 1'b0; i_is_load_ex = 1'b0; i_data_memory_address_ex = '0;
      i_load_byte_enable_ex = '0; i_cache_write_enable = 1'b0; i_cache_write_index = '0;
      i_cache_write_data = '0; i_cache_write_tag = '0; i_cache_write_valid = '0;
      i_cache_byte_write_enable = '0; i_invalidate_req = 1'b0; pre_en = 1'b0;
      pre_idx = '0; pre_data = '0; pre_tag = '0; pre_valid = '0;
   endtask

   typedef struct {
      logic [31:0]   addr;
      logic [3:0]    be;
      logic [TW-1:0] p_tag;
      logic [3:0]    p_valid;
      logic [31:0]   p_data;
      logic          w_en;
      logic [31:0]   w_data;
      logic [3:0]    w_be;
      logic [3:0]    w_valid;
      logic [TW-1:0] w_tag;
      logic [IW-1:0] exp_idx;
      logic          exp_hit;
      logic [31:0]   exp_data;
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input int n, input vec_t v);
      pre_en = 1'b1; pre_idx = v.exp_idx; pre_data = v.p_data;
      pre_tag = v.p_tag; pre_valid = v.p_valid;
      tick();
      pre_en = 1'b0;
      i_is_load_ex = 1'b1; i_data_memory_address_ex = v.addr; i_load_byte_enable_ex = v.be;
      i_cache_write_enable = v.w_en; i_cache_write_index = v.exp_idx;
      i_cache_write_data = v.w_data; i_cache_byte_write_enable = v.w_be;
      i_cache_write_valid = v.w_valid; i_cache_write_tag = v.w_tag;
      @(negedge i_clk);
      check($sformatf("vec%0d_read_index", n), 32'(o_cache_read_index), 32'(v.exp_idx));
      tick();
      i_is_load_ex = 1'b0; i_cache_write_enable = 1'b0;
      @(negedge i_clk);
      check($sformatf("vec%0d_hit", n), 32'(o_cache_hit_on_load), 32'(v.exp_hit));
      check($sformatf("vec%0d_data", n), o_cache_read_data_ma, v.exp_data);
      tick();
   endtask

   // Model of the load sitting in MA, kept from the pipeline rules only.
   logic          ma_load;
   logic          ma_mmio;
   logic [IW-1:0] ma_idx;
   logic [TW-1:0] ma_tag;
   logic [3:0]    ma_be;

   task automatic random_phase(input int cycles);
      logic exp_hit;
      logic [IW-1:0] exp_ridx;
      ma_load = 1'b0; ma_mmio = 1'b0; ma_idx = '0; ma_tag = '0; ma_be = '0;
      for (int c = 0; c < cycles; c++) begin
         i_stall = (c > 0) && ($urandom_range(0, 3) == 0);
         i_is_load_ex = ($urandom_range(0, 9) < 7);
         i_data_memory_address_ex = (($urandom_range(0, 7) == 0) ? 32'h4000_0000 : 32'h0)
                                    | (32'($urandom_range(0, 3)) << 9)
                                    | (32'($urandom_range(0, 7)) << 2)
                                    | 32'($urandom_range(0, 3));
         i_load_byte_enable_ex = 4'($urandom_range(1, 15));
         i_cache_write_enable = $urandom_range(0, 1) == 1;
         i_cache_write_index = 7'($urandom_range(0, 7));
         i_cache_write_data = $urandom;
         i_cache_write_tag = 7'($urandom_range(0, 3));
         i_cache_write_valid = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
         i_cache_byte_write_enable = 4'($urandom_range(0, 15));
         @(negedge i_clk);
         exp_hit = ma_load && !ma_mmio && (mem_tag[ma_idx] == ma_tag)
                   && ((ma_be & ~mem_valid[ma_idx]) == 4'h0);
         check("rnd_hit", 32'(o_cache_hit_on_load), 32'(exp_hit));
         if (ma_load)
            check("rnd_data", o_cache_read_data_ma, mem_data[ma_idx]);
         exp_ridx = i_stall ? ma_idx : idx_of(i_data_memory_address_ex);
         check("rnd_read_index", 32'(o_cache_read_index), 32'(exp_ridx));
         check("rnd_busy", 32'(o_invalidate_busy), 32'd0);
         @(posedge i_clk);
         if (!i_stall) begin
            ma_load = i_is_load_ex;
            ma_mmio = i_data_memory_address_ex >= 32'h4000_0000;
            ma_idx  = idx_of(i_data_memory_address_ex);
            ma_tag  = tag_of(i_data_memory_address_ex);
            ma_be   = i_load_byte_enable_ex;
         end
         #1;
      end
      idle_inputs();
   endtask

   // Requests a sweep; with n_sweeps == 2 a second request arrives at sweep cycle 50.
   task automatic sweep_test(input int n_sweeps);
      int seen [N];
      int bad;
      int done_cnt;
      int cyc;
      logic [IW-1:0] exp_i;
      for (int i = 0; i < N; i++) seen[i] = 0;
      done_cnt = 0;
      i_invalidate_req = 1'b1;
      @(negedge i_clk);
      check("sweep_accept_busy", 32'(o_invalidate_busy), 32'd1);
      check("sweep_accept_we", 32'(o_inval_write_enable), 32'd0);
      tick();
      i_invalidate_req = 1'b0;
      for (int c = 0; c < n_sweeps * N; c++) begin
         i_invalidate_req = (n_sweeps == 2) && (c == 50);
         @(negedge i_clk);
         exp_i = 7'(c % N);
         check("sweep_we", 32'(o_inval_write_enable), 32'd1);
         check("sweep_index", 32'(o_inval_write_index), 32'(exp_i));
         check("sweep_busy", 32'(o_invalidate_busy), 32'd1);
         check("sweep_done", 32'(o_invalidate_done), 32'(exp_i == 7'(N - 1)));
         if (o_inval_write_enable) seen[o_inval_write_index]++;
         if (o_invalidate_done) done_cnt++;
         tick();
      end
      i_invalidate_req = 1'b0;
      @(negedge i_clk);
      check("sweep_end_busy", 32'(o_invalidate_busy), 32'd0);
      check("sweep_end_we", 32'(o_inval_write_enable), 32'd0);
      bad = 0;
      for (int i = 0; i < N; i++) if (seen[i] != n_sweeps) bad++;
      check("sweep_each_index_once", 32'(bad), 32'd0);
      check("sweep_done_count", 32'(done_cnt), 32'(n_sweeps));
      // Bounded watch that the block stays idle.
      cyc = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge i_clk);
         if (o_invalidate_busy || o_inval_write_enable || o_invalidate_done) cyc++;
      end
      check("sweep_stays_idle", 32'(cyc), 32'd0);
      tick();
   endtask

   task automatic reset_abort_test();
      int stray;
      i_invalidate_req = 1'b1;
      tick();
      i_invalidate_req = 1'b0;
      for (int c = 0; c < 40; c++) tick();
      @(negedge i_clk);
      check("abort_index_40", 32'(o_inval_write_index), 32'd40);
      tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      @(negedge i_clk);
      check("abort_busy_after_rst", 32'(o_invalidate_busy), 32'd0);
      stray = 0;
      for (int c = 0; c < 150; c++) begin
         @(negedge i_clk);
         if (o_invalidate_done || o_invalidate_busy || o_inval_write_enable) stray++;
      end
      check("abort_no_done_or_busy", 32'(stray), 32'd0);
      tick();
      i_invalidate_req = 1'b1;
      tick();
      i_invalidate_req = 1'b0;
      @(negedge i_clk);
      check("abort_restart_we", 32'(o_inval_write_enable), 32'd1);
      check("abort_restart_index", 32'(o_inval_write_index), 32'd0);
      // Let this sweep finish before leaving.
      for (int c = 0; c < N + 2; c++) tick();
      @(negedge i_clk);
      check("abort_restart_finishes", 32'(o_invalidate_busy), 32'd0);
   endtask

   initial begin
      vecs[0] = '{32'h0000_0104, 4'hF, 7'd0, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, 4'h0, 4'h0, 7'd0,
                  7'h41, 1'b1, 32'hDEAD_BEEF};
      vecs[1] = '{32'h0000_0208, 4'h3, 7'd1, 4'h3, 32'h0102_0304, 1'b0, 32'h0, 4'h0, 4'h0, 7'd0,
                  7'h02, 1'b1, 32'h0102_0304};
      vecs[2] = '{32'h0000_0208, 4'hC, 7'd1, 4'h3, 32'h0102_0304, 1'b0, 32'h0, 4'h0, 4'h0, 7'd0,
                  7'h02, 1'b0, 32'h0102_0304};
      vecs[3] = '{32'h0000_030C, 4'hF, 7'd1, 4'h0, 32'h1122_3344, 1'b1, 32'hAABB_CCDD, 4'h2, 4'hF, 7'd1,
                  7'h43, 1'b1, 32'h1122_CC44};
      vecs[4] = '{32'h4000_0000, 4'hF, 7'd0, 4'hF, 32'h5566_7788, 1'b0, 32'h0, 4'h0, 4'h0, 7'd0,
                  7'h00, 1'b0, 32'h5566_7788};
      vecs[5] = '{32'h0000_0104, 4'hF, 7'd5, 4'hF, 32'h0BAD_0BAD, 1'b0, 32'h0, 4'h0, 4'h0, 7'd0,
                  7'h41, 1'b0, 32'h0BAD_0BAD};
      vecs[6] = '{32'h0000_030C, 4'hF, 7'd1, 4'hF, 32'h0000_0000, 1'b1, 32'h1234_5678, 4'hF, 4'hF, 7'd2,
                  7'h43, 1'b0, 32'h1234_5678};
      vecs[7] = '{32'h0000_0208, 4'h3, 7'd1, 4'h0, 32'hCAFE_F00D, 1'b1, 32'hFFFF_FFFF, 4'h0, 4'h3, 7'd1,
                  7'h02, 1'b1, 32'hCAFE_F00D};

      idle_inputs();
      i_rst = 1'b1;
      tick();
      tick();
      @(negedge i_clk);
      check("rst_busy", 32'(o_invalidate_busy), 32'd0);
      check("rst_we", 32'(o_inval_write_enable), 32'd0);
      check("rst_done", 32'(o_invalidate_done), 32'd0);
      check("rst_hit", 32'(o_cache_hit_on_load), 32'd0);
      check("rst_data", o_cache_read_data_ma, 32'd0);
      tick();
      i_rst = 1'b0;
      @(negedge i_clk);
      check("post_rst_hit", 32'(o_cache_hit_on_load), 32'd0);
      tick();

      for (int n = 0; n < 8; n++) run_vec(n, vecs[n]);

      for (int i = 0; i < 8; i++) begin
         pre_en = 1'b1; pre_idx = 7'(i); pre_data = $urandom;
         pre_tag = 7'($urandom_range(0, 3)); pre_valid = 4'($urandom_range(0, 15));
         tick();
      end
      pre_en = 1'b0;
      tick();
      random_phase(500);
      tick();

      sweep_test(1);
      sweep_test(2);
      reset_abort_test();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
